// File: rtl/alu_cdb_unit.sv
// rtl/alu_cdb_unit.sv - single-issue ALU with one-entry result buffer broadcasting on the CDB
// Optional feature macro: ALU_MUL_EN (signed multiply, opcode 6'h18, three BUSY cycles)
module alu_cdb_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rs_valid_out,
   input  logic [5:0]  alu_opcode,
   input  logic [31:0] alu_op1,
   input  logic [31:0] alu_op2,
   input  logic [4:0]  alu_dest_tag,
   output logic        alu_ready,
   output logic        cdb_req,
   input  logic        cdb_grant,
   output logic        cdb_valid,
   output logic [4:0]  cdb_tag,
   output logic [31:0] cdb_data
);

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SLT = 6'h2A;
   localparam logic [5:0] OP_SLL = 6'h00;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_SRA = 6'h03;

`ifdef ALU_MUL_EN
   localparam logic [5:0] OP_MUL = 6'h18;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

   state_t      r_state;
   state_t      w_next_state;
   logic [4:0]  r_tag;
   logic [31:0] r_data;
   logic [31:0] w_result;
   logic [4:0]  w_shamt;
   logic        w_release;
   logic        w_accept;

`ifdef ALU_MUL_EN
   logic [1:0]  r_cnt;
   logic [1:0]  w_next_cnt;
   logic [31:0] w_product;
   logic        w_is_mul;

   // The low word of a two's-complement product does not depend on signedness.
   assign w_product = alu_op1 * alu_op2;
   assign w_is_mul  = (alu_opcode == OP_MUL);
`endif

   assign w_shamt   = alu_op2[4:0];
   assign w_release = (r_state == S_HOLD) && cdb_grant;
   assign alu_ready = (r_state == S_IDLE) || w_release;
   assign w_accept  = rs_valid_out && alu_ready;

   always_comb begin
      w_result = 32'h0;
      case (alu_opcode)
         OP_ADD: w_result = alu_op1 + alu_op2;
         OP_SUB: w_result = alu_op1 - alu_op2;
         OP_AND: w_result = alu_op1 & alu_op2;
         OP_OR:  w_result = alu_op1 | alu_op2;
         OP_XOR: w_result = alu_op1 ^ alu_op2;
         OP_NOR: w_result = ~(alu_op1 | alu_op2);
         OP_SLT: w_result = {31'h0, ($signed(alu_op1) < $signed(alu_op2))};
         OP_SLL: w_result = alu_op1 << w_shamt;
         OP_SRL: w_result = alu_op1 >> w_shamt;
         OP_SRA: w_result = $signed(alu_op1) >>> w_shamt;
`ifdef ALU_MUL_EN
         OP_MUL: w_result = w_product;
`endif
         default: w_result = 32'h0;
      endcase
   end

   // A new accept always wins over the grant-driven return to IDLE.
   always_comb begin
      w_next_state = r_state;
`ifdef ALU_MUL_EN
      w_next_cnt = r_cnt;
`endif
      if (w_accept) begin
         w_next_state = S_HOLD;
`ifdef ALU_MUL_EN
         if (w_is_mul) begin
            w_next_state = S_BUSY;
            w_next_cnt   = 2'd0;
         end
`endif
      end else begin
         case (r_state)
            S_HOLD: if (cdb_grant) w_next_state = S_IDLE;
`ifdef ALU_MUL_EN
            S_BUSY: begin
               if (r_cnt == 2'd2) w_next_state = S_HOLD;
               else               w_next_cnt   = r_cnt + 2'd1;
            end
`endif
            default: w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tag   <= 5'h0;
         r_data  <= 32'h0;
`ifdef ALU_MUL_EN
         r_cnt   <= 2'd0;
`endif
      end else begin
         r_state <= w_next_state;
`ifdef ALU_MUL_EN
         r_cnt   <= w_next_cnt;
`endif
         if (w_accept) begin
            r_tag  <= alu_dest_tag;
            r_data <= w_result;
         end
      end
   end

   assign cdb_req   = (r_state == S_HOLD);
   assign cdb_valid = w_release;
   assign cdb_tag   = w_release ? r_tag  : 5'h0;
   assign cdb_data  = w_release ? r_data : 32'h0;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// tb/tb_alu_cdb_unit.sv - directed scenarios plus randomized traffic against a transaction-level model
// Honors ALU_MUL_EN when defined for the build
module tb_alu_cdb_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rs_valid_out = 1'b0;
   logic [5:0]  alu_opcode = 6'h0;
   logic [31:0] alu_op1 = 32'h0;
   logic [31:0] alu_op2 = 32'h0;
   logic [4:0]  alu_dest_tag = 5'h0;
   logic        cdb_grant = 1'b0;
   logic        alu_ready;
   logic        cdb_req;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_data;

   int n_cmp = 0;
   int n_err = 0;

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   alu_cdb_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rs_valid_out (rs_valid_out),
      .alu_opcode   (alu_opcode),
      .alu_op1      (alu_op1),
      .alu_op2      (alu_op2),
      .alu_dest_tag (alu_dest_tag),
      .alu_ready    (alu_ready),
      .cdb_req      (cdb_req),
      .cdb_grant    (cdb_grant),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data)
   );

   always #5 clk = ~clk;

   // Snapshot of all outputs as {ready, req, valid, tag, data}.
   function automatic logic [39:0] outs();
      return {alu_ready, cdb_req, cdb_valid, cdb_tag, cdb_data};
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic g);
      rs_valid_out = v;
      alu_opcode   = op;
      alu_op1      = a;
      alu_op2      = b;
      alu_dest_tag = t;
      cdb_grant    = g;
   endtask

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      case (op)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
         6'h00: return a << sh;
         6'h02: return a >> sh;
         6'h03: return 32'(sa >>> sh);
         6'h18: return MUL_EN ? 32'(sa * sb) : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   localparam logic [39:0] IDLE_OUT = {1'b1, 1'b0, 1'b0, 5'd0, 32'h0};

   task automatic test_reset();
      #12;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL reset_during: got %h expected %h", outs(), IDLE_OUT);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL reset_after: got %h expected %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_add_overflow();
      logic [39:0] exp;
      @(negedge clk);
      drive(1, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd5, 1);
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd5, 32'h80000000};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL add_bcast: got %h expected %h", outs(), exp);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL add_idle: got %h expected %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_slt_hold();
      logic [39:0] exp;
      @(negedge clk);
      drive(1, 6'h2A, 32'hFFFFFFFF, 32'h0, 5'd3, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1, 6'h20, 32'h1, 32'h1, 5'd7, 0);
         #1;
         exp = {1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL slt_wait%0d: got %h expected %h", i, outs(), exp);
         end
      end
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd3, 32'h1};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL slt_bcast: got %h expected %h", outs(), exp);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL slt_idle: got %h expected %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] exp;
      @(negedge clk);
      drive(1, 6'h22, 32'd10, 32'd3, 5'd1, 1);
      @(negedge clk);
      drive(1, 6'h03, 32'h80000000, 32'd4, 5'd2, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd1, 32'd7};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL b2b_first: got %h expected %h", outs(), exp);
      end
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd2, 32'hF8000000};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL b2b_second: got %h expected %h", outs(), exp);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL b2b_idle: got %h expected %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_mul();
      logic [39:0] exp;
      @(negedge clk);
      drive(1, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd9, 1);
      if (MUL_EN) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 6'h20, 32'h5, 32'h5, 5'd8, 1);
            #1;
            exp = {1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
            n_cmp++;
            if (outs() !== exp) begin
               n_err++;
               $display("FAIL mul_busy%0d: got %h expected %h", i, outs(), exp);
            end
         end
      end
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd9, MUL_EN ? 32'hFFFFFFEB : 32'h0};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL mul_bcast: got %h expected %h", outs(), exp);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL mul_idle: got %h expected %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_unsupported();
      logic [39:0] exp;
      @(negedge clk);
      drive(1, 6'h3F, 32'h12345678, 32'h9ABCDEF0, 5'd4, 1);
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      #1;
      exp = {1'b1, 1'b1, 1'b1, 5'd4, 32'h0};
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL unsup_bcast: got %h expected %h", outs(), exp);
      end
   endtask

   task automatic test_reset_in_flight(input logic [5:0] op, input string name);
      @(negedge clk);
      drive(1, op, 32'h11, 32'h22, 5'd6, 0);
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL %s_rst_async: got %h expected %h", name, outs(), IDLE_OUT);
      end
      cdb_grant = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== IDLE_OUT) begin
         n_err++;
         $display("FAIL %s_rst_grant: got %h expected %h", name, outs(), IDLE_OUT);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (outs() !== IDLE_OUT) begin
            n_err++;
            $display("FAIL %s_rst_after%0d: got %h expected %h", name, i, outs(), IDLE_OUT);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0]  ops [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h00, 6'h02, 6'h03, 6'h18, 6'h3F};
      bit          m_full;
      int          m_wait;
      logic [4:0]  m_tag;
      logic [31:0] m_data;
      logic        v, g, e_ready, e_valid;
      logic [5:0]  op;
      logic [31:0] a, b;
      logic [4:0]  t;
      logic [39:0] exp;
      int          bad;
      m_full = 0;
      m_wait = 0;
      m_tag  = 0;
      m_data = 0;
      bad    = 0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         v  = ($urandom_range(0, 3) != 0);
         op = ops[$urandom_range(0, 11)];
         a  = $urandom;
         b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         t  = 5'($urandom);
         g  = ($urandom_range(0, 2) != 0);
         drive(v, op, a, b, t, g);
         #1;
         e_ready = !m_full || (m_wait == 0 && g);
         e_valid = m_full && m_wait == 0 && g;
         exp = {e_ready, m_full && m_wait == 0, e_valid,
                e_valid ? m_tag : 5'd0, e_valid ? m_data : 32'h0};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            bad++;
            if (bad <= 10)
               $display("FAIL rand_cycle%0d: got %h expected %h (op %h a %h b %h)", i, outs(), exp, op, a, b);
         end
         if (v && e_ready) begin
            m_full = 1;
            m_tag  = t;
            m_data = ref_alu(op, a, b);
            m_wait = (MUL_EN && op == 6'h18) ? 3 : 0;
         end else if (e_valid) begin
            m_full = 0;
         end else if (m_full && m_wait > 0) begin
            m_wait--;
         end
      end
      @(negedge clk);
      drive(0, 6'h0, 0, 0, 0, 1);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_overflow();
      test_slt_hold();
      test_back_to_back();
      test_mul();
      test_unsupported();
      test_reset_in_flight(6'h20, "hold");
      test_reset_in_flight(6'h18, "busy");
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
